// File: rtl/mem_arbiter.sv
// Sole master of the shared 4-cycle main memory: grants I-cache fills and D-cache
// fills/write-throughs, sequences each to completion and steers returned words.
module mem_arbiter #(
   parameter  int ADDR_W = 16,
   parameter  int DATA_W = 16,
   parameter  int WORDS  = 8,
   parameter  int OFF_W  = 4,
   localparam int CNT_W  = $clog2(WORDS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ic_req,
   input  logic [ADDR_W-1:0] ic_addr,
   input  logic              dc_req,
   input  logic              dc_wr,
   input  logic [ADDR_W-1:0] dc_addr,
   input  logic [DATA_W-1:0] dc_wdata,
   output logic              ic_fill_we,
   output logic              dc_fill_we,
   output logic [CNT_W-1:0]  fill_word,
   output logic [DATA_W-1:0] fill_data,
   output logic              ic_done,
   output logic              dc_done,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_enable,
   output logic              mem_wr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_data_valid,
   output logic              busy
);

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_WRITE, S_DONE} state_t;
   typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_t;

   state_t              r_state;
   state_t              w_next_state;
   owner_t              r_owner;
   owner_t              r_last_grant;
   logic [ADDR_W-1:0]   r_base;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [CNT_W-1:0]    r_issue_cnt;
   logic [CNT_W-1:0]    r_recv_cnt;

   logic                w_grant_any;
   logic                w_grant_d;
   logic [ADDR_W-1:0]   w_sel_addr;
   logic                w_recv;
   logic                w_recv_last;
   logic                w_issue_last;

   // On a tie the requester that did not win last time takes the grant.
   assign w_grant_any  = ic_req | dc_req;
   assign w_grant_d    = dc_req & (~ic_req | (r_last_grant == OWN_I));
   assign w_sel_addr   = w_grant_d ? dc_addr : ic_addr;
   assign w_recv       = mem_data_valid & ((r_state == S_ISSUE) | (r_state == S_DRAIN));
   assign w_recv_last  = w_recv & (r_recv_cnt == CNT_W'(WORDS - 1));
   assign w_issue_last = (r_issue_cnt == CNT_W'(WORDS - 1));

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // the pre-edge value of its inputs, independent of process evaluation order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // NOTE: every variable written in a combinational block gets a default first,
   // otherwise a path that skips the assignment would infer a latch.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_grant_any) begin
               w_next_state = (w_grant_d && dc_wr) ? S_WRITE : S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (w_recv_last) begin
               w_next_state = S_DONE;
            end else if (w_issue_last) begin
               w_next_state = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (w_recv_last) begin
               w_next_state = S_DONE;
            end
         end
         S_WRITE: w_next_state = S_DONE;
         S_DONE:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // NOTE: the datapath registers are few and all reset, so a mid-transaction reset
   // leaves no stale owner, address or counter behind.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_owner      <= OWN_I;
         r_last_grant <= OWN_D;
         r_base       <= '0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_issue_cnt  <= '0;
         r_recv_cnt   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_grant_any) begin
                  r_owner      <= w_grant_d ? OWN_D : OWN_I;
                  r_last_grant <= w_grant_d ? OWN_D : OWN_I;
                  r_base       <= {w_sel_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                  r_addr       <= w_sel_addr;
                  r_wdata      <= dc_wdata;
               end
            end
            S_ISSUE: r_issue_cnt <= r_issue_cnt + CNT_W'(1);
            S_DONE: begin
               r_issue_cnt <= '0;
               r_recv_cnt  <= '0;
            end
            default: ;
         endcase
         if (w_recv) begin
            r_recv_cnt <= r_recv_cnt + CNT_W'(1);
         end
      end
   end

   always_comb begin
      mem_enable = 1'b0;
      mem_wr     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      ic_fill_we = 1'b0;
      dc_fill_we = 1'b0;
      fill_word  = '0;
      fill_data  = '0;
      ic_done    = 1'b0;
      dc_done    = 1'b0;
      busy       = (r_state != S_IDLE);
      case (r_state)
         S_ISSUE: begin
            mem_enable = 1'b1;
            mem_addr   = r_base + (ADDR_W'(r_issue_cnt) << 1);
         end
         S_WRITE: begin
            mem_enable = 1'b1;
            mem_wr     = 1'b1;
            mem_addr   = r_addr;
            mem_wdata  = r_wdata;
         end
         S_DONE: begin
            ic_done = (r_owner == OWN_I);
            dc_done = (r_owner == OWN_D);
         end
         default: ;
      endcase
      // Returned words go only to the cache that owns the current transaction.
      if (w_recv) begin
         ic_fill_we = (r_owner == OWN_I);
         dc_fill_we = (r_owner == OWN_D);
         fill_word  = r_recv_cnt;
         fill_data  = mem_rdata;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a 4-cycle memory model plus scoreboards for
// memory requests, fill words and done pulses, filled when stimulus is driven.
`timescale 1ns/1ps
module tb_mem_arbiter;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 16;
   localparam int WORDS  = 8;
   localparam int OFF_W  = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              ic_req = 1'b0;
   logic [15:0]       ic_addr = '0;
   logic              dc_req = 1'b0;
   logic              dc_wr = 1'b0;
   logic [15:0]       dc_addr = '0;
   logic [15:0]       dc_wdata = '0;
   logic              ic_fill_we, dc_fill_we, ic_done, dc_done;
   logic [2:0]        fill_word;
   logic [15:0]       fill_data, mem_addr, mem_wdata;
   logic              mem_enable, mem_wr, busy;
   logic [15:0]       mem_rdata = '0;
   logic              m_valid = 1'b0;
   logic              spur_valid = 1'b0;
   logic              mem_data_valid;

   assign mem_data_valid = m_valid | spur_valid;

   mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS(WORDS), .OFF_W(OFF_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .ic_req(ic_req), .ic_addr(ic_addr),
      .dc_req(dc_req), .dc_wr(dc_wr), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
      .ic_fill_we(ic_fill_we), .dc_fill_we(dc_fill_we),
      .fill_word(fill_word), .fill_data(fill_data),
      .ic_done(ic_done), .dc_done(dc_done),
      .mem_addr(mem_addr), .mem_enable(mem_enable), .mem_wr(mem_wr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_data_valid(mem_data_valid),
      .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [15:0] mdata(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'h3C3C;
   endfunction

   function automatic logic [63:0] all_out();
      return {6'd0, ic_fill_we, dc_fill_we, fill_word, fill_data, ic_done, dc_done,
              mem_addr, mem_enable, mem_wr, mem_wdata, busy};
   endfunction

   // Memory model: a read issued in cycle c returns its word in cycle c+3.
   logic        d_v [3];
   logic [15:0] d_a [3];
   initial for (int i = 0; i < 3; i++) begin d_v[i] = 1'b0; d_a[i] = '0; end

   always @(posedge clk) begin
      #1;
      m_valid   = d_v[2];
      mem_rdata = d_v[2] ? mdata(d_a[2]) : 16'h0;
      d_v[2] = d_v[1]; d_a[2] = d_a[1];
      d_v[1] = d_v[0]; d_a[1] = d_a[0];
      d_v[0] = (mem_enable === 1'b1) && (mem_wr === 1'b0);
      d_a[0] = mem_addr;
   end

   typedef struct packed { logic wr; logic [15:0] addr; logic [15:0] wdata; } mreq_t;
   typedef struct packed { logic own; logic [2:0] word; logic [15:0] data; } fill_t;

   mreq_t mem_q [$];
   fill_t fill_q [$];
   logic  done_q [$];

   logic mon_on = 1'b0;
   int   en_cnt = 0, first_en = -1, last_en = -1, last_wr_cyc = -1;

   always @(negedge clk) begin
      if (mon_on) begin
         if (mem_enable) begin
            en_cnt++;
            if (first_en < 0) first_en = cyc;
            last_en = cyc;
            if (mem_wr) last_wr_cyc = cyc;
            if (mem_q.size() == 0) check("mem_unexpected", mem_enable, 1'b0);
            else check("mem_req", {mem_wr, mem_addr, mem_wdata}, mem_q.pop_front());
         end else begin
            check("mem_quiet", {mem_wr, mem_addr, mem_wdata}, 0);
         end
         if (ic_fill_we || dc_fill_we) begin
            check("fill_exclusive", ic_fill_we & dc_fill_we, 0);
            if (fill_q.size() == 0) check("fill_unexpected", {ic_fill_we, dc_fill_we}, 0);
            else check("fill", {dc_fill_we, fill_word, fill_data}, fill_q.pop_front());
         end
         if (ic_done || dc_done) begin
            check("done_exclusive", ic_done & dc_done, 0);
            if (done_q.size() == 0) check("done_unexpected", {ic_done, dc_done}, 0);
            else check("done_owner", dc_done, done_q.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic push_fill(input logic own, input logic [15:0] base);
      for (int w = 0; w < WORDS; w++) begin
         mem_q.push_back('{wr: 1'b0, addr: base + 16'(2 * w), wdata: 16'h0});
         fill_q.push_back('{own: own, word: 3'(w), data: mdata(base + 16'(2 * w))});
      end
      done_q.push_back(own);
   endtask

   task automatic push_write(input logic [15:0] a, input logic [15:0] d);
      mem_q.push_back('{wr: 1'b1, addr: a, wdata: d});
      done_q.push_back(1'b1);
   endtask

   // Returns during the done cycle so the caller can drop its request in time.
   task automatic wait_done(input string tag, input logic own, output int at);
      logic seen = 1'b0;
      at = -1;
      for (int k = 0; k < 100 && !seen; k++) begin
         tick();
         if (own ? dc_done : ic_done) begin
            seen = 1'b1;
            at   = cyc;
         end
      end
      check(tag, seen, 1'b1);
   endtask

   initial begin
      int g, t_i, t_d, n_ic, n_dc;
      logic re_i, re_d;

      // Reset state
      rst_n = 1'b0;
      repeat (3) tick();
      check("reset_outputs", all_out(), 0);
      rst_n = 1'b1;
      mon_on = 1'b1;
      tick();

      // Single I-cache fill with the 3-cycle-return memory
      push_fill(1'b0, 16'h1230);
      en_cnt = 0; first_en = -1;
      ic_addr = 16'h1236; ic_req = 1'b1; g = cyc;
      wait_done("ic_fill_timeout", 1'b0, t_i);
      ic_req = 1'b0;
      check("ic_done_latency", 32'(t_i - g), 12);
      check("issue_count", en_cnt, WORDS);
      check("issue_span", 32'(last_en - first_en), WORDS - 1);
      tick();

      // Tie right after an I grant: D wins first
      push_fill(1'b1, 16'h8000);
      push_fill(1'b0, 16'h3000);
      ic_addr = 16'h3008; dc_addr = 16'h8000; dc_wr = 1'b0;
      ic_req = 1'b1; dc_req = 1'b1;
      wait_done("tie_d_timeout", 1'b1, t_d);
      dc_req = 1'b0;
      wait_done("tie_i_timeout", 1'b0, t_i);
      ic_req = 1'b0;
      tick();

      // D-cache write-through
      push_write(16'h4002, 16'hBEEF);
      dc_wr = 1'b1; dc_addr = 16'h4002; dc_wdata = 16'hBEEF; dc_req = 1'b1; g = cyc;
      wait_done("wr_timeout", 1'b1, t_d);
      dc_req = 1'b0;
      check("wr_cycle", 32'(last_wr_cyc - g), 1);
      check("wr_done_latency", 32'(t_d - g), 2);
      tick();

      // D write request arriving during an I fill waits for it
      push_fill(1'b0, 16'h5000);
      push_write(16'h6006, 16'h1234);
      ic_addr = 16'h500E; ic_req = 1'b1;
      repeat (3) tick();
      dc_wr = 1'b1; dc_addr = 16'h6006; dc_wdata = 16'h1234; dc_req = 1'b1;
      wait_done("pend_i_timeout", 1'b0, t_i);
      ic_req = 1'b0;
      wait_done("pend_d_timeout", 1'b1, t_d);
      dc_req = 1'b0;
      check("pend_wr_cycle", 32'(last_wr_cyc - t_i), 2);
      check("pend_done_gap", 32'(t_d - t_i), 3);
      tick();

      // Fresh reset, both requests held: I, D, I, D
      rst_n = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      push_fill(1'b0, 16'h2010);
      push_fill(1'b1, 16'h8000);
      push_fill(1'b0, 16'h2010);
      push_fill(1'b1, 16'h8000);
      ic_addr = 16'h2010; dc_addr = 16'h8000; dc_wr = 1'b0;
      ic_req = 1'b1; dc_req = 1'b1;
      n_ic = 0; n_dc = 0; re_i = 1'b0; re_d = 1'b0;
      for (int k = 0; k < 300 && (n_ic + n_dc) < 4; k++) begin
         tick();
         if (re_i) begin ic_req = 1'b1; re_i = 1'b0; end
         if (re_d) begin dc_req = 1'b1; re_d = 1'b0; end
         if (ic_done) begin ic_req = 1'b0; n_ic++; re_i = (n_ic < 2); end
         if (dc_done) begin dc_req = 1'b0; n_dc++; re_d = (n_dc < 2); end
      end
      check("alt_ic_count", n_ic, 2);
      check("alt_dc_count", n_dc, 2);
      tick();

      // Reset during the 5th ISSUE cycle of an I fill
      for (int w = 0; w < 5; w++) mem_q.push_back('{wr: 1'b0, addr: 16'h7000 + 16'(2 * w), wdata: 16'h0});
      for (int w = 0; w < 2; w++) fill_q.push_back('{own: 1'b0, word: 3'(w), data: mdata(16'h7000 + 16'(2 * w))});
      ic_addr = 16'h7000; ic_req = 1'b1;
      tick();
      check("abort_busy", busy, 1'b1);
      repeat (4) tick();
      rst_n = 1'b0; ic_req = 1'b0;
      tick();
      rst_n = 1'b1;
      check("abort_outputs", all_out(), 0);
      for (int k = 0; k < 6; k++) begin
         tick();
         check("abort_quiet", {ic_fill_we, dc_fill_we, ic_done, dc_done, busy}, 0);
      end

      // Stray valid in IDLE, then a D fill still returns words 0..7
      spur_valid = 1'b1;
      check("spur_no_we", {ic_fill_we, dc_fill_we}, 0);
      tick();
      spur_valid = 1'b0;
      push_fill(1'b1, 16'h8000);
      dc_wr = 1'b0; dc_addr = 16'h8004; dc_req = 1'b1;
      wait_done("spur_fill_timeout", 1'b1, t_d);
      dc_req = 1'b0;
      repeat (6) tick();

      check("mem_q_left", 32'(mem_q.size()), 0);
      check("fill_q_left", 32'(fill_q.size()), 0);
      check("done_q_left", 32'(done_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
